paddle_ctrl: RTL

Upstream stage of the VGA pong renderer. It turns four raw player buttons into the two paddle vertical positions, `pos_l` and `pos_r`, that the renderer compares against its vertical counter. Each button is synchronised and debounced at frame rate. Each paddle has a small motion state machine with clamping and optional hold-to-accelerate. Positions change only on the frame strobe, so a paddle never moves mid-frame.

---
 rtl/paddle_ctrl.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/paddle_ctrl.sv
// Pong paddle controller: synchronises and debounces four buttons, runs two paddle motion FSMs.
// Optional hold-to-accelerate (FAST states, hold counter) is compiled in when PADDLE_ACCEL_EN is defined.
module paddle_ctrl #(
    parameter int V_ACTIVE        = 480,
    parameter int PADDLE_H        = 64,
    parameter int STEP            = 4,
    parameter int DEBOUNCE_FRAMES = 3,
    parameter int ACCEL_FRAMES    = 16,
    parameter int POS_W           = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frame,
    input  logic             btn_l_up,
    input  logic             btn_l_dn,
    input  logic             btn_r_up,
    input  logic             btn_r_dn,
    output logic [POS_W-1:0] pos_l,
    output logic [POS_W-1:0] pos_r,
    output logic             moving_l,
    output logic             moving_r
);

    localparam int CNT_W = 4;
    localparam logic [POS_W-1:0]   POS_RESET = POS_W'((V_ACTIVE - PADDLE_H) / 2);
    localparam logic signed [POS_W:0] MAX_S  = (POS_W+1)'(V_ACTIVE - PADDLE_H);
    localparam logic signed [POS_W:0] SLOW_S = (POS_W+1)'(STEP);
`ifdef PADDLE_ACCEL_EN
    localparam logic signed [POS_W:0] FAST_S = (POS_W+1)'(2 * STEP);

    typedef enum logic [2:0] {IDLE, SLOW_UP, FAST_UP, SLOW_DN, FAST_DN} state_t;
`else
    typedef enum logic [1:0] {IDLE, SLOW_UP, SLOW_DN} state_t;
`endif

    // Button index: 0 = left up, 1 = left down, 2 = right up, 3 = right down.
    logic [3:0]       raw;
    logic [3:0]       sync_a;
    logic [3:0]       sync_b;
    logic [3:0]       stable;
    logic [CNT_W-1:0] db_cnt [4];
    logic [POS_W-1:0] pos_arr [2];
    logic [1:0]       moving_arr;

    assign raw = {btn_r_dn, btn_r_up, btn_l_dn, btn_l_up};

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_a <= '0;
            sync_b <= '0;
        end else begin
            sync_a <= raw;
            sync_b <= sync_a;
        end
    end

    // A change is accepted only after DEBOUNCE_FRAMES consecutive differing frame samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            stable <= '0;
            for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
        end else if (frame) begin
            for (int i = 0; i < 4; i++) begin
                if (sync_b[i] != stable[i]) begin
                    if (db_cnt[i] == CNT_W'(DEBOUNCE_FRAMES - 1)) begin
                        stable[i] <= sync_b[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + 1'b1;
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    for (genvar p = 0; p < 2; p++) begin : g_paddle
        state_t                  state;
        state_t                  state_nx;
        logic [POS_W-1:0]        pos;
        logic [POS_W-1:0]        pos_nx;
        logic signed [POS_W:0]   cur;
        logic signed [POS_W:0]   moved;
        logic                    req_up;
        logic                    req_dn;
`ifdef PADDLE_ACCEL_EN
        logic [7:0]              hold;
        logic [7:0]              hold_nx;
`endif

        // Requests come from the debounced bits as they stood before this strobe.
        assign req_up = stable[2*p]   & ~stable[2*p+1];
        assign req_dn = stable[2*p+1] & ~stable[2*p];

        always_comb begin
            state_nx = state;
`ifdef PADDLE_ACCEL_EN
            hold_nx  = hold;
`endif
            if (frame) begin
                case (state)
                    SLOW_UP: begin
                        if (req_up) begin
`ifdef PADDLE_ACCEL_EN
                            if (hold + 8'd1 == 8'(ACCEL_FRAMES)) begin
                                state_nx = FAST_UP;
                                hold_nx  = '0;
                            end else begin
                                hold_nx  = hold + 8'd1;
                            end
`else
                            state_nx = SLOW_UP;
`endif
                        end else begin
                            state_nx = req_dn ? SLOW_DN : IDLE;
`ifdef PADDLE_ACCEL_EN
                            hold_nx  = '0;
`endif
                        end
                    end
                    SLOW_DN: begin
                        if (req_dn) begin
`ifdef PADDLE_ACCEL_EN
                            if (hold + 8'd1 == 8'(ACCEL_FRAMES)) begin
                                state_nx = FAST_DN;
                                hold_nx  = '0;
                            end else begin
                                hold_nx  = hold + 8'd1;
                            end
`else
                            state_nx = SLOW_DN;
`endif
                        end else begin
                            state_nx = req_up ? SLOW_UP : IDLE;
`ifdef PADDLE_ACCEL_EN
                            hold_nx  = '0;
`endif
                        end
                    end
`ifdef PADDLE_ACCEL_EN
                    FAST_UP: begin
                        state_nx = req_up ? FAST_UP : (req_dn ? SLOW_DN : IDLE);
                        hold_nx  = '0;
                    end
                    FAST_DN: begin
                        state_nx = req_dn ? FAST_DN : (req_up ? SLOW_UP : IDLE);
                        hold_nx  = '0;
                    end
`endif
                    default: begin
                        state_nx = req_up ? SLOW_UP : (req_dn ? SLOW_DN : IDLE);
`ifdef PADDLE_ACCEL_EN
                        hold_nx  = '0;
`endif
                    end
                endcase
            end
        end

        // Move by the step of the state being entered; one extra bit lets underflow clamp to 0.
        always_comb begin
            cur   = {1'b0, pos};
            moved = cur;
            case (state_nx)
                SLOW_UP: moved = cur - SLOW_S;
                SLOW_DN: moved = cur + SLOW_S;
`ifdef PADDLE_ACCEL_EN
                FAST_UP: moved = cur - FAST_S;
                FAST_DN: moved = cur + FAST_S;
`endif
                default: moved = cur;
            endcase
            if (moved < 0)
                pos_nx = '0;
            else if (moved > MAX_S)
                pos_nx = MAX_S[POS_W-1:0];
            else
                pos_nx = moved[POS_W-1:0];
            if (!frame)
                pos_nx = pos;
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                state <= IDLE;
                pos   <= POS_RESET;
`ifdef PADDLE_ACCEL_EN
                hold  <= '0;
`endif
            end else begin
                state <= state_nx;
                pos   <= pos_nx;
`ifdef PADDLE_ACCEL_EN
                hold  <= hold_nx;
`endif
            end
        end

        assign pos_arr[p]    = pos;
        assign moving_arr[p] = (state != IDLE);
    end

    assign pos_l    = pos_arr[0];
    assign pos_r    = pos_arr[1];
    assign moving_l = moving_arr[0];
    assign moving_r = moving_arr[1];

endmodule
